// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int BIT_PERIOD = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 expire;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign expire = (timer_q == TIMER_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Outputs are registered, so each branch drives the value for the state being entered.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_start) begin
          state_d   = START;
          shift_d   = tx_data;
          timer_d   = '0;
          bit_cnt_d = '0;
          serial_d  = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      START: begin
        if (expire) begin
          state_d  = DATA;
          timer_d  = '0;
          serial_d = shift_q[0];
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (expire) begin
          timer_d   = '0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = parity_q;
`else
            state_d  = STOP;
            serial_d = 1'b1;
`endif
          end else begin
            serial_d = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (expire) begin
          state_d  = STOP;
          timer_d  = '0;
          serial_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          state_d  = IDLE;
          timer_d  = '0;
          serial_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        timer_d  = '0;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign serial_out = serial_q;

endmodule
